// File: rtl/sign_magnitude_addsub_pipe.sv
// Three-stage sign-magnitude adder/subtractor for the fp16 mantissa path.
// One global advance enable stalls every stage together when the output is held.
module sign_magnitude_addsub_pipe #(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_op,
   input  logic             i_lhs_sign,
   input  logic [WIDTH-1:0] i_lhs_magnitude,
   input  logic             i_rhs_sign,
   input  logic [WIDTH-1:0] i_rhs_magnitude,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_sign,
   output logic [WIDTH-1:0] o_magnitude,
   output logic             o_overflow,
   output logic             o_zero
);

   logic en;

   logic             s1_valid;
   logic [WIDTH:0]   s1_big;
   logic [WIDTH:0]   s1_small;
   logic             s1_sign;
   logic             s1_eff_sub;

   logic             s2_valid;
   logic [WIDTH:0]   s2_sum;
   logic             s2_sign;

   logic             s3_valid;
   logic             s3_sign;
   logic [WIDTH-1:0] s3_magnitude;
   logic             s3_overflow;
   logic             s3_zero;

   assign en      = !s3_valid || i_ready;
   assign o_ready = en;

   // S1 decode: fold the op into the rhs sign, then order operands so big >= small
   logic           eff_rhs_sign;
   logic           swap;
   logic [WIDTH:0] dec_big;
   logic [WIDTH:0] dec_small;
   logic           dec_sign;
   logic           dec_eff_sub;

   always_comb begin
      eff_rhs_sign = i_rhs_sign ^ i_op;
      swap         = (i_lhs_magnitude < i_rhs_magnitude);
      dec_big      = swap ? {1'b0, i_rhs_magnitude} : {1'b0, i_lhs_magnitude};
      dec_small    = swap ? {1'b0, i_lhs_magnitude} : {1'b0, i_rhs_magnitude};
      dec_sign     = swap ? eff_rhs_sign : i_lhs_sign;
      dec_eff_sub  = i_lhs_sign ^ eff_rhs_sign;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid   <= 1'b0;
         s1_big     <= '0;
         s1_small   <= '0;
         s1_sign    <= 1'b0;
         s1_eff_sub <= 1'b0;
      end else if (en) begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_big     <= dec_big;
            s1_small   <= dec_small;
            s1_sign    <= dec_sign;
            s1_eff_sub <= dec_eff_sub;
         end
      end
   end

   // S2: big >= small, so the subtract path cannot borrow out of the top bit
   logic [WIDTH:0] sum;

   always_comb begin
      sum = s1_eff_sub ? (s1_big - s1_small) : (s1_big + s1_small);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid <= 1'b0;
         s2_sum   <= '0;
         s2_sign  <= 1'b0;
      end else if (en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sum  <= sum;
            s2_sign <= s1_sign;
         end
      end
   end

   // S3: overflow, optional clamp, and zero forced positive
   logic             res_overflow;
   logic [WIDTH-1:0] res_magnitude;
   logic             res_zero;
   logic             res_sign;

   always_comb begin
      res_overflow  = s2_sum[WIDTH];
      res_magnitude = (SATURATE && res_overflow) ? {WIDTH{1'b1}} : s2_sum[WIDTH-1:0];
      res_zero      = (res_magnitude == '0) && !res_overflow;
      res_sign      = s2_sign && !res_zero;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s3_valid     <= 1'b0;
         s3_sign      <= 1'b0;
         s3_magnitude <= '0;
         s3_overflow  <= 1'b0;
         s3_zero      <= 1'b0;
      end else if (en) begin
         s3_valid <= s2_valid;
         if (s2_valid) begin
            s3_sign      <= res_sign;
            s3_magnitude <= res_magnitude;
            s3_overflow  <= res_overflow;
            s3_zero      <= res_zero;
         end
      end
   end

   assign o_valid     = s3_valid;
   assign o_sign      = s3_sign;
   assign o_magnitude = s3_magnitude;
   assign o_overflow  = s3_overflow;
   assign o_zero      = s3_zero;

endmodule

// File: doc/sign_magnitude_addsub_pipe.md
# sign_magnitude_addsub_pipe

Pipelined, parametrised sign-magnitude adder/subtractor with valid/ready flow control. It accepts one operation per cycle and selects add or subtract per transaction. Zero results are always positive, and overflow is either reported as wrap-around or saturated. It sits in the fp16 datapath as the mantissa add/sub stage, between operand alignment and normalisation.

## Interface

Parameters:
- WIDTH, 16: magnitude width in bits (≥ 2).
- SATURATE, 0: 0 gives a wrapped magnitude on overflow; 1 clamps the magnitude to all-ones on overflow.

Ports:
- i_clk, input, 1: clock. All state is updated on the rising edge.
- i_rst, input, 1: reset. Asynchronous, active-high.
- i_valid, input, 1: input transaction present.
- o_ready, output, 1: block can accept an input this cycle.
- i_op, input, 1: 0 computes lhs + rhs; 1 computes lhs − rhs.
- i_lhs_sign, input, 1: lhs sign (1 = negative).
- i_lhs_magnitude, input, WIDTH: lhs magnitude.
- i_rhs_sign, input, 1: rhs sign.
- i_rhs_magnitude, input, WIDTH: rhs magnitude.
- o_valid, output, 1: result present.
- i_ready, input, 1: downstream accepts the result.
- o_sign, output, 1: result sign.
- o_magnitude, output, WIDTH: result magnitude.
- o_overflow, output, 1: true sum magnitude ≥ 2^WIDTH.
- o_zero, output, 1: result magnitude is zero.

## Operation

- The pipeline has 3 stages: S1, S2, S3. Each stage holds a valid bit and a data register.
- S1 captures the inputs and decodes them:
  - Effective rhs sign = i_rhs_sign XOR i_op.
  - swap = (lhs_mag < rhs_mag). Equal magnitudes do not swap.
  - Register the big/small operand (magnitudes zero-extended to WIDTH+1), the result sign (= sign of the big operand), and eff_sub = (lhs_sign ≠ eff_rhs_sign).
- S2 computes the sum on WIDTH+1 bits:
  - eff_sub = 0: sum = big + small.
  - eff_sub = 1: sum = big − small. This never underflows because big ≥ small.
- S3 forms the result:
  - overflow = sum[WIDTH]. It can only be set when eff_sub = 0.
  - Magnitude = sum[WIDTH-1:0], or all-ones when SATURATE=1 and overflow=1.
  - zero = (magnitude == 0) AND NOT overflow.
  - When zero=1, the sign is forced to 0. This covers −0 ± 0 and x − x: no negative zero is ever emitted.
- The outputs are driven directly from the S3 registers.

## Timing

- Stall scheme: a single global advance, en = !o_valid || i_ready. o_ready = en (combinational). When en = 1, all stages shift by one.
- An input handshake completes when i_valid && o_ready. An output handshake completes when o_valid && i_ready.
- Latency: a result appears on o_valid exactly 3 cycles after its input handshake, provided there is no stall.
- Throughput: 1 transaction per cycle.
- Stall (o_valid=1, i_ready=0):
  - Every stage holds its contents.
  - o_sign, o_magnitude, o_overflow and o_zero stay stable.
  - o_ready=0.
- Bubbles are not collapsed. Empty stages ahead of a stalled S3 still wait, because this is a global stall.
- Ordering: results emerge strictly in input order. No transaction is dropped or duplicated.
- i_valid=0 while en=1 inserts a bubble: S1's valid bit is cleared.
- Reset:
  - i_rst=1 clears all valid bits immediately (asynchronously).
  - All outputs go to 0: o_valid, o_sign, o_magnitude, o_overflow, o_zero. o_ready = 1.
  - In-flight transactions are discarded.
  - The first accepted input after reset deasserts appears 3 cycles later.
- Data registers hold don't-care contents when their valid bit is 0. The outputs must still read 0 until the first result arrives.

## Test plan

All scenarios use WIDTH=16 unless stated.

- Mixed-sign add: op=0, lhs = +5, rhs = −3, i_ready held 1.
  - o_valid exactly 3 cycles later, with sign=0, mag=0x0002, overflow=0, zero=0.
- Subtract with sign flip: op=1, lhs = +3, rhs = +5.
  - sign=1, mag=0x0002.
- Subtract of negatives: op=1, lhs = −4, rhs = −4.
  - sign=0, mag=0, zero=1. No negative zero.
- Overflow: op=0, lhs = +0xFFFF, rhs = +0x0001.
  - SATURATE=0: sign=0, mag=0x0000, overflow=1, zero=0.
  - SATURATE=1: mag=0xFFFF, overflow=1.
- Backpressure: drive 6 back-to-back transactions, each a += a for a = 1..6. Hold i_ready=0 for 4 cycles starting when the first o_valid rises.
  - o_ready=0 throughout the stall. Outputs stay stable.
  - Results 2, 4, 6, 8, 10, 12 arrive in order, with no loss or duplication.
- Reset mid-stream: assert i_rst asynchronously while 3 transactions are in flight.
  - o_valid and all outputs are 0 immediately. o_ready=1.
  - After release, input +1 + +1 yields mag=2 exactly 3 cycles after its handshake. No stale results appear.
